// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder
//   Packs assembled instruction fields (opcode, Rx, Ry, imm) into 16-bit
//   instruction words and writes them to consecutive instruction-memory
//   halfwords. The CPU is held while a load session is running. It is used for
//   boot/program load and by processor benches.
//
// Ports
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start, i_base_addr begin a session at i_base_addr (bit 0 forced to 0)
//   i_op_valid/o_op_ready  field-set handshake; i_opcode/i_rx/i_ry/i_imm/i_op_last
//   o_mem_we/o_mem_addr/o_mem_wdata/i_mem_ack  instruction-memory write port
//   o_cpu_hold           CPU hold request while loading or in error
//   o_done               1-cycle pulse when the session completes
//   o_error/o_err_code   sticky error (1 illegal op, 2 imm range, 3 overflow)
//   o_words_written      words committed in the current/last session
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no session; waiting for start
// ACCEPT | ready for the next field set; CPU held
// WRITE  | encoded word presented to memory until acked
// DONE   | one-cycle completion pulse; CPU released
// ERR    | session aborted; error/err_code held; CPU held until restart
module instr_stream_encoder #(
  parameter int ADDR_W    = 16,
  parameter int MAX_WORDS = 256
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_start,
  input  logic [ADDR_W-1:0]                  i_base_addr,
  input  logic                               i_op_valid,
  output logic                               o_op_ready,
  input  logic [4:0]                         i_opcode,
  input  logic [2:0]                         i_rx,
  input  logic [2:0]                         i_ry,
  input  logic [10:0]                        i_imm,
  input  logic                               i_op_last,
  output logic                               o_mem_we,
  output logic [ADDR_W-1:0]                  o_mem_addr,
  output logic [15:0]                        o_mem_wdata,
  input  logic                               i_mem_ack,
  output logic                               o_cpu_hold,
  output logic                               o_done,
  output logic                               o_error,
  output logic [1:0]                         o_err_code,
  output logic [$clog2(MAX_WORDS+1)-1:0]     o_words_written
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_IMM     = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;

  localparam logic [4:0] OP_MVHI = 5'b10110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_last;
  logic [CNT_W-1:0]  r_count;
  logic [1:0]        r_err_code;

  logic              w_legal;
  logic              w_imm_ok;
  logic [15:0]       w_word;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_write_done;
  logic [CNT_W-1:0]  w_cnt_inc;

  // Opcode legality and word packing. Format is selected by opcode[4:3].
  always_comb begin
    w_legal  = 1'b0;
    w_imm_ok = 1'b1;
    w_word   = 16'h0000;

    case (i_opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
      5'b01000, 5'b01001, 5'b01010, 5'b01100,
      5'b11000, 5'b11001, 5'b11010, 5'b11100: w_legal = 1'b1;
      default:                                 w_legal = 1'b0;
    endcase

    case (i_opcode[4:3])
      2'b00:   w_word = {5'b00000, i_ry, i_rx, i_opcode};
      2'b01:   w_word = {8'h00, i_rx, i_opcode};
      2'b10:   w_word = {i_imm[7:0], i_rx, i_opcode};
      default: w_word = {i_imm, i_opcode};
    endcase

    // imm8 forms take a signed byte; mvhi loads an unsigned high byte.
    if (i_opcode[4:3] == 2'b10) begin
      if (i_opcode == OP_MVHI) begin
        w_imm_ok = (i_imm[10:8] == 3'b000);
      end else begin
        w_imm_ok = (i_imm[10:8] == {3{i_imm[7]}});
      end
    end
  end

  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                    (r_state == S_ERR));
  assign w_accept     = (r_state == S_ACCEPT) && i_op_valid;
  assign w_write_done = (r_state == S_WRITE) && i_mem_ack;
  assign w_cnt_inc    = r_count + CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_op_ready = 1'b0;
    o_mem_we   = 1'b0;
    o_cpu_hold = 1'b0;
    o_done     = 1'b0;
    o_error    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        o_op_ready = 1'b1;
        o_cpu_hold = 1'b1;
        if (i_op_valid) begin
          if (!w_legal || !w_imm_ok) w_next = S_ERR;
          else                       w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_mem_we   = 1'b1;
        o_cpu_hold = 1'b1;
        if (i_mem_ack) begin
          if (r_last)                    w_next = S_DONE;
          else if (w_cnt_inc == MAX_CNT) w_next = S_ERR;
          else                           w_next = S_ACCEPT;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = i_start ? S_ACCEPT : S_IDLE;
      end
      S_ERR: begin
        o_error    = 1'b1;
        o_cpu_hold = 1'b1;
        if (i_start) w_next = S_ACCEPT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_start_ok) begin
        r_addr     <= i_base_addr & {{(ADDR_W-1){1'b1}}, 1'b0};
        r_count    <= '0;
        r_err_code <= ERR_NONE;
      end

      if (w_accept) begin
        r_wdata <= w_word;
        r_last  <= i_op_last;
        if (!w_legal)       r_err_code <= ERR_ILLEGAL;
        else if (!w_imm_ok) r_err_code <= ERR_IMM;
      end

      // Address wraps modulo 2^ADDR_W by design.
      if (w_write_done) begin
        r_count <= w_cnt_inc;
        r_addr  <= r_addr + ADDR_W'(2);
        if (!r_last && (w_cnt_inc == MAX_CNT)) r_err_code <= ERR_OVF;
      end
    end
  end

  assign o_mem_addr      = r_addr;
  assign o_mem_wdata     = r_wdata;
  assign o_err_code      = r_err_code;
  assign o_words_written = r_count;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder, built with MAX_WORDS=4 so the overflow
// path is reachable. Expected memory writes are queued as each field set
// is offered. A memory responder pops and compares them when it acks.
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_base_addr = '0;
  logic        i_op_valid = 1'b0;
  logic        o_op_ready;
  logic [4:0]  i_opcode = '0;
  logic [2:0]  i_rx = '0;
  logic [2:0]  i_ry = '0;
  logic [10:0] i_imm = '0;
  logic        i_op_last = 1'b0;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic        o_cpu_hold;
  logic        o_done;
  logic        o_error;
  logic [1:0]  o_err_code;
  logic [2:0]  o_words_written;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] exp_addr = '0;
  int          ack_delay = 0;
  int          checks = 0;
  int          errors = 0;

  instr_stream_encoder #(.ADDR_W(16), .MAX_WORDS(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_opcode(i_opcode),
    .i_rx(i_rx), .i_ry(i_ry), .i_imm(i_imm), .i_op_last(i_op_last),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .o_cpu_hold(o_cpu_hold), .o_done(o_done),
    .o_error(o_error), .o_err_code(o_err_code), .o_words_written(o_words_written)
  );

  always #5 clk = ~clk;

  // Memory model: acks a write after ack_delay low cycles.
  task automatic responder();
    int wait_cnt = 0;
    wr_t f;
    forever begin
      @(negedge clk);
      if (o_mem_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write addr=%h data=%h", o_mem_addr, o_mem_wdata);
          i_mem_ack = 1'b1;
        end else begin
          f = exp_q[0];
          checks++;
          if (o_mem_addr !== f.a || o_mem_wdata !== f.d || o_op_ready !== 1'b0) begin
            errors++;
            $display("FAIL mem_write addr=%h data=%h ready=%b expected addr=%h data=%h ready=0",
                     o_mem_addr, o_mem_wdata, o_op_ready, f.a, f.d);
          end
          if (wait_cnt >= ack_delay) begin
            i_mem_ack = 1'b1;
            void'(exp_q.pop_front());
            wait_cnt = 0;
          end else begin
            i_mem_ack = 1'b0;
            wait_cnt++;
          end
        end
      end else begin
        i_mem_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  endtask

  task automatic start_session(input logic [15:0] base);
    @(negedge clk);
    i_start = 1'b1;
    i_base_addr = base;
    @(negedge clk);
    i_start = 1'b0;
    exp_addr = base & 16'hFFFE;
    checks++;
    if (o_op_ready !== 1'b1 || o_error !== 1'b0 || o_err_code !== 2'd0 ||
        o_words_written !== 3'd0 || o_cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL start ready=%b error=%b code=%0d words=%0d hold=%b expected 1 0 0 0 1",
               o_op_ready, o_error, o_err_code, o_words_written, o_cpu_hold);
    end
  endtask

  // Offers one field set; if exp_ok the write {exp_addr, exp_data} is expected.
  task automatic send_op(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                         input logic [10:0] imm, input logic last, input logic exp_ok,
                         input logic [15:0] exp_data);
    int n = 0;
    @(negedge clk);
    i_op_valid = 1'b1; i_opcode = op; i_rx = rx; i_ry = ry; i_imm = imm; i_op_last = last;
    while (!o_op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL op_ready_timeout op=%b", op);
      i_op_valid = 1'b0;
      return;
    end
    if (exp_ok) begin
      exp_q.push_back({exp_addr, exp_data});
      exp_addr = exp_addr + 16'd2;
    end
    @(negedge clk);
    i_op_valid = 1'b0;
    checks++;
    if (o_mem_we !== exp_ok) begin
      errors++;
      $display("FAIL accept_to_we op=%b mem_we=%b expected %b", op, o_mem_we, exp_ok);
    end
  endtask

  task automatic wait_done(input logic [2:0] exp_words);
    int n = 0;
    while (!o_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL done_timeout done=%b expected 1", o_done);
      return;
    end
    if (o_cpu_hold !== 1'b0 || o_words_written !== exp_words || o_op_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle hold=%b words=%0d ready=%b expected 0 %0d 0",
               o_cpu_hold, o_words_written, o_op_ready, exp_words);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_words_written !== exp_words || o_cpu_hold !== 1'b0) begin
      errors++;
      $display("FAIL done_after done=%b words=%0d hold=%b expected 0 %0d 0",
               o_done, o_words_written, o_cpu_hold, exp_words);
    end
  endtask

  task automatic check_err(input string name, input logic [1:0] code);
    checks++;
    if (o_error !== 1'b1 || o_err_code !== code || o_cpu_hold !== 1'b1 ||
        o_mem_we !== 1'b0 || o_op_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s error=%b code=%0d hold=%b we=%b ready=%b expected 1 %0d 1 0 0",
               name, o_error, o_err_code, o_cpu_hold, o_mem_we, o_op_ready, code);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_op_ready !== 0 || o_mem_we !== 0 || o_cpu_hold !== 0 || o_done !== 0 ||
        o_error !== 0 || o_err_code !== 0 || o_words_written !== 0 ||
        o_mem_addr !== 0 || o_mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset ready=%b we=%b hold=%b done=%b err=%b code=%0d words=%0d addr=%h data=%h expected all 0",
               o_op_ready, o_mem_we, o_cpu_hold, o_done, o_error, o_err_code,
               o_words_written, o_mem_addr, o_mem_wdata);
    end
    i_reset = 1'b0;
  endtask

  task automatic test_basic();
    start_session(16'h0040);
    send_op(5'b10000, 3'd3, 3'd0, 11'h7FB, 1'b0, 1'b1, 16'hFB70);
    send_op(5'b00001, 3'd1, 3'd2, 11'h000, 1'b1, 1'b1, 16'h0221);
    wait_done(3'd2);
  endtask

  task automatic test_jump();
    start_session(16'h0101);
    send_op(5'b11000, 3'd5, 3'd6, 11'h400, 1'b1, 1'b1, 16'h8018);
    wait_done(3'd1);
  endtask

  task automatic test_illegal();
    start_session(16'h0000);
    send_op(5'b00110, 3'd1, 3'd1, 11'h000, 1'b0, 1'b0, 16'h0000);
    check_err("illegal_opcode", 2'd1);
    repeat (3) @(negedge clk);
    check_err("illegal_sticky", 2'd1);
  endtask

  task automatic test_imm_range();
    start_session(16'h0010);
    send_op(5'b10001, 3'd2, 3'd0, 11'h080, 1'b0, 1'b0, 16'h0000);
    check_err("addi_range", 2'd2);
    start_session(16'h0010);
    send_op(5'b10110, 3'd5, 3'd0, 11'h0FF, 1'b1, 1'b1, 16'hFFB6);
    wait_done(3'd1);
  endtask

  task automatic test_ack_stall();
    ack_delay = 5;
    start_session(16'h0200);
    send_op(5'b00000, 3'd7, 3'd3, 11'h155, 1'b0, 1'b1, 16'h03E0);
    // start during WRITE must not relocate the session
    i_start = 1'b1; i_base_addr = 16'h2000;
    @(negedge clk);
    i_start = 1'b0;
    send_op(5'b00101, 3'd2, 3'd4, 11'h000, 1'b1, 1'b1, 16'h0445);
    wait_done(3'd2);
    ack_delay = 0;
  endtask

  task automatic test_overflow();
    int n = 0;
    start_session(16'hFFFC);
    send_op(5'b01000, 3'd6, 3'd7, 11'h7FF, 1'b0, 1'b1, 16'h00C8);
    send_op(5'b01100, 3'd1, 3'd0, 11'h000, 1'b0, 1'b1, 16'h002C);
    send_op(5'b10011, 3'd0, 3'd0, 11'h005, 1'b0, 1'b1, 16'h0513);
    send_op(5'b10010, 3'd2, 3'd0, 11'h7FF, 1'b0, 1'b1, 16'hFF52);
    while (!o_error && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_err("overflow", 2'd3);
    checks++;
    if (o_words_written !== 3'd4) begin
      errors++;
      $display("FAIL overflow_words words=%0d expected 4", o_words_written);
    end
    i_op_valid = 1'b1; i_opcode = 5'b11100; i_imm = 11'h001; i_op_last = 1'b0;
    repeat (3) @(negedge clk);
    i_op_valid = 1'b0;
    check_err("overflow_fifth_refused", 2'd3);
  endtask

  task automatic test_reset_mid_write();
    ack_delay = 10;
    start_session(16'h0300);
    send_op(5'b10001, 3'd1, 3'd0, 11'h010, 1'b0, 1'b1, 16'h1031);
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (o_mem_we !== 0 || o_op_ready !== 0 || o_cpu_hold !== 0 ||
        o_words_written !== 0 || o_error !== 0) begin
      errors++;
      $display("FAIL reset_mid_write we=%b ready=%b hold=%b words=%0d err=%b expected all 0",
               o_mem_we, o_op_ready, o_cpu_hold, o_words_written, o_error);
    end
    i_reset = 1'b0;
    exp_q.delete();
    ack_delay = 0;
    start_session(16'h0000);
    send_op(5'b00011, 3'd0, 3'd1, 11'h000, 1'b1, 1'b1, 16'h0103);
    wait_done(3'd1);
  endtask

  initial begin
    fork
      responder();
    join_none
    test_reset();
    test_basic();
    test_jump();
    test_illegal();
    test_imm_range();
    test_ack_stall();
    test_overflow();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
